// File: rtl/axilm_pkg.sv
// Shared types and helpers for the AXI4-Lite master read path.
//   resp_e     : AXI response codes
//   PROT_*     : ARPROT/AWPROT bit constants
//   ar_state_e : address-stage states
//   cnt_w()    : width of a counter that must hold 0..n inclusive
package axilm_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_e;

   localparam logic [2:0] PROT_UNPRIV_SECURE_DATA = 3'b000;
   localparam logic [2:0] PROT_PRIVILEGED         = 3'b001;
   localparam logic [2:0] PROT_NONSECURE          = 3'b010;
   localparam logic [2:0] PROT_INSTRUCTION        = 3'b100;

   typedef enum logic {
      AR_IDLE  = 1'b0,
      AR_VALID = 1'b1
   } ar_state_e;

   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/axilm_rsp_fifo.sv
// Synchronous show-ahead FIFO: head entry is always visible on dout.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write strobe and data (ignored when full without a pop)
//   pop          read strobe (ignored when empty)
//   dout         head entry
//   full, empty  fill status
//   count        number of stored entries (0..DEPTH)
module axilm_rsp_fifo #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Explicit wrap so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage, pointers and fill count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/axilm_rd_pipe.sv
// AXI4-Lite master read engine: pipelined AR issue, up to MAX_OUTS reads
// outstanding, in-order response buffering and a sticky response timeout.
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   AR*/R*                  AXI4-Lite read address / read data channels
//   BUS_ENA/WSTB/ADDR       local request (all-zero strobes = read)
//   BUS_BUSY                request cannot be accepted this cycle
//   BUS_RVALID/RREADY       local response handshake
//   BUS_RDATA/RRESP         response at FIFO head
//   BUS_TIMEOUT             sticky timeout flag
//   OUTS_CNT                accepted reads not yet popped locally
module axilm_rd_pipe import axilm_pkg::*; #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_OUTS    = 4,
   parameter logic [2:0]  PROT_VAL    = 3'b000,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   output logic [ADDR_W-1:0]               ARADDR,
   output logic [2:0]                      ARPROT,
   output logic                            ARVALID,
   input  logic                            ARREADY,
   input  logic [DATA_W-1:0]               RDATA,
   input  logic [1:0]                      RRESP,
   input  logic                            RVALID,
   output logic                            RREADY,
   input  logic                            BUS_ENA,
   input  logic [DATA_W/8-1:0]             BUS_WSTB,
   input  logic [ADDR_W-1:0]               BUS_ADDR,
   output logic                            BUS_BUSY,
   output logic                            BUS_RVALID,
   input  logic                            BUS_RREADY,
   output logic [DATA_W-1:0]               BUS_RDATA,
   output logic [1:0]                      BUS_RRESP,
   output logic                            BUS_TIMEOUT,
   output logic [$clog2(MAX_OUTS+1)-1:0]   OUTS_CNT
);

   localparam int unsigned CNT_W = cnt_w(MAX_OUTS);
   localparam int unsigned RSP_W = DATA_W + 2;

   ar_state_e         state_q;
   ar_state_e         state_d;
   logic [ADDR_W-1:0] araddr_d;
   logic              rd_req;
   logic              accept;
   logic              pop;
   logic              push;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [CNT_W-1:0]  inflight;
   logic              fifo_full;
   logic              fifo_empty;
   logic [RSP_W-1:0]  rsp_head;

   assign ARPROT   = PROT_VAL;
   assign ARVALID  = (state_q == AR_VALID);
   assign rd_req   = BUS_ENA & ~|BUS_WSTB;
   assign BUS_BUSY = (ARVALID & ~ARREADY) | (OUTS_CNT == CNT_W'(MAX_OUTS));
   assign accept   = rd_req & ~BUS_BUSY;
   assign pop      = BUS_RVALID & BUS_RREADY;

   // Reads handed to the slave and not yet returned.
   assign inflight = OUTS_CNT - fifo_cnt - CNT_W'(ARVALID);
   // fifo_full can never coincide with inflight != 0; kept as a guard.
   assign RREADY   = (inflight != '0) & ~fifo_full;
   assign push     = RVALID & RREADY;

   // Address stage next-state: reload on accept, drop ARVALID once taken.
   always_comb begin
      state_d  = state_q;
      araddr_d = ARADDR;
      case (state_q)
         AR_IDLE: begin
            if (accept) begin
               state_d  = AR_VALID;
               araddr_d = BUS_ADDR;
            end
         end
         AR_VALID: begin
            if (ARREADY) begin
               if (accept) araddr_d = BUS_ADDR;
               else        state_d  = AR_IDLE;
            end
         end
         default: state_d = AR_IDLE;
      endcase
   end

   // Address stage and outstanding-count registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q  <= AR_IDLE;
         ARADDR   <= '0;
         OUTS_CNT <= '0;
      end else begin
         state_q  <= state_d;
         ARADDR   <= araddr_d;
         OUTS_CNT <= OUTS_CNT + CNT_W'(accept) - CNT_W'(pop);
      end
   end

   axilm_rsp_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (MAX_OUTS)
   ) u_rsp_fifo (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (push),
      .din   ({RDATA, RRESP}),
      .pop   (pop),
      .dout  (rsp_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   assign BUS_RVALID             = ~fifo_empty;
   assign {BUS_RDATA, BUS_RRESP} = rsp_head;

   // Response timeout: counts stalled cycles with reads in flight.
   if (TIMEOUT_CYC > 0) begin : g_timeout
      localparam int unsigned TO_W = cnt_w(TIMEOUT_CYC);
      logic [TO_W-1:0] to_cnt;
      logic            to_flag;

      always_ff @(posedge ACLK or posedge ARESET) begin
         if (ARESET) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
         end else if (push || (inflight == '0)) begin
            to_cnt <= '0;
         end else if (to_cnt != TO_W'(TIMEOUT_CYC)) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) to_flag <= 1'b1;
         end
      end

      assign BUS_TIMEOUT = to_flag;
   end else begin : g_no_timeout
      assign BUS_TIMEOUT = 1'b0;
   end

endmodule

// File: tb/tb_axilm_rd_pipe.sv
// Randomized bench for axilm_rd_pipe with a queue-based transaction model
// and a delayed-response AXI-Lite slave.
module tb_axilm_rd_pipe;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned MAX_OUTS    = 4;
   localparam int unsigned TIMEOUT_CYC = 8;
   localparam int unsigned CNT_W       = $clog2(MAX_OUTS + 1);

   logic                ACLK = 1'b0;
   logic                ARESET = 1'b1;
   logic [ADDR_W-1:0]   ARADDR;
   logic [2:0]          ARPROT;
   logic                ARVALID;
   logic                ARREADY;
   logic [DATA_W-1:0]   RDATA;
   logic [1:0]          RRESP;
   logic                RVALID;
   logic                RREADY;
   logic                BUS_ENA;
   logic [DATA_W/8-1:0] BUS_WSTB;
   logic [ADDR_W-1:0]   BUS_ADDR;
   logic                BUS_BUSY;
   logic                BUS_RVALID;
   logic                BUS_RREADY;
   logic [DATA_W-1:0]   BUS_RDATA;
   logic [1:0]          BUS_RRESP;
   logic                BUS_TIMEOUT;
   logic [CNT_W-1:0]    OUTS_CNT;

   always #5 ACLK = ~ACLK;

   axilm_rd_pipe #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .MAX_OUTS    (MAX_OUTS),
      .PROT_VAL    (3'b010),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .ARADDR      (ARADDR),
      .ARPROT      (ARPROT),
      .ARVALID     (ARVALID),
      .ARREADY     (ARREADY),
      .RDATA       (RDATA),
      .RRESP       (RRESP),
      .RVALID      (RVALID),
      .RREADY      (RREADY),
      .BUS_ENA     (BUS_ENA),
      .BUS_WSTB    (BUS_WSTB),
      .BUS_ADDR    (BUS_ADDR),
      .BUS_BUSY    (BUS_BUSY),
      .BUS_RVALID  (BUS_RVALID),
      .BUS_RREADY  (BUS_RREADY),
      .BUS_RDATA   (BUS_RDATA),
      .BUS_RRESP   (BUS_RRESP),
      .BUS_TIMEOUT (BUS_TIMEOUT),
      .OUTS_CNT    (OUTS_CNT)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      int          rdy;
   } sl_t;

   // Reference model state
   logic [31:0] ar_q[$];    // accepted, address not yet taken by slave
   sl_t         sl_q[$];    // taken by slave, response not yet returned
   logic [33:0] rsp_q[$];   // returned, waiting for local consumer
   int          outs_m;
   int          wc_m;
   bit          to_m;

   // Slave / stimulus controls
   int          cyc;
   int          ar_rdy_pct = 100;
   int          dly_min = 1;
   int          dly_max = 1;
   int          resp_sel = 0;
   bit          hold_r = 1'b0;
   bit          inject_rv = 1'b0;
   bit          fix_data_en = 1'b0;
   logic [31:0] fix_data = '0;

   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic drive(input bit ena, input logic [3:0] wstb, input logic [31:0] addr, input bit rrdy);
      BUS_ENA    = ena;
      BUS_WSTB   = wstb;
      BUS_ADDR   = addr;
      BUS_RREADY = rrdy;
   endtask

   task automatic chk_reset_vals();
      chk("rst_ARVALID", ARVALID, 0);
      chk("rst_ARADDR", ARADDR, 0);
      chk("rst_RREADY", RREADY, 0);
      chk("rst_BUS_RVALID", BUS_RVALID, 0);
      chk("rst_BUS_RDATA", BUS_RDATA, 0);
      chk("rst_BUS_RRESP", BUS_RRESP, 0);
      chk("rst_BUS_TIMEOUT", BUS_TIMEOUT, 0);
      chk("rst_OUTS_CNT", OUTS_CNT, 0);
      chk("rst_BUS_BUSY", BUS_BUSY, 0);
   endtask

   // One clock cycle: slave drives, combinational checks, edge, model update,
   // registered checks. Entered and left at posedge+1.
   task automatic cycle();
      bit  busy_e, rrdy_e, acc_e, arhs_e, rhs_e, pop_e;
      sl_t e;
      ARREADY = ($urandom_range(99) < ar_rdy_pct);
      if (!hold_r && sl_q.size() != 0 && sl_q[0].rdy <= cyc) begin
         RVALID = 1'b1;
         RDATA  = sl_q[0].data;
         RRESP  = sl_q[0].resp;
      end else begin
         RVALID = inject_rv;
         RDATA  = $urandom;
         RRESP  = 2'($urandom);
      end
      #1;
      busy_e = (ar_q.size() != 0 && !ARREADY) || (outs_m == int'(MAX_OUTS));
      rrdy_e = (sl_q.size() != 0);
      chk("BUS_BUSY", BUS_BUSY, busy_e);
      chk("RREADY", RREADY, rrdy_e);
      acc_e  = BUS_ENA && (BUS_WSTB == '0) && !busy_e;
      arhs_e = (ar_q.size() != 0) && ARREADY;
      rhs_e  = RVALID && rrdy_e;
      pop_e  = (rsp_q.size() != 0) && BUS_RREADY;
      @(posedge ACLK);
      cyc++;
      if (pop_e) void'(rsp_q.pop_front());
      if (rhs_e) begin
         e = sl_q.pop_front();
         rsp_q.push_back({e.data, e.resp});
      end
      if (arhs_e) begin
         logic [31:0] a;
         a      = ar_q.pop_front();
         e.data = fix_data_en ? fix_data : mem_data(a);
         e.resp = (resp_sel >= 0) ? 2'(resp_sel) : 2'($urandom);
         e.rdy  = cyc + int'($urandom_range(dly_max, dly_min)) - 1;
         sl_q.push_back(e);
      end
      if (acc_e) ar_q.push_back(BUS_ADDR);
      outs_m = outs_m + int'(acc_e) - int'(pop_e);
      if (rrdy_e && !rhs_e) begin
         if (wc_m < int'(TIMEOUT_CYC)) wc_m++;
         if (wc_m == int'(TIMEOUT_CYC)) to_m = 1'b1;
      end else begin
         wc_m = 0;
      end
      #1;
      chk("ARVALID", ARVALID, ar_q.size() != 0);
      if (ar_q.size() != 0) chk("ARADDR", ARADDR, ar_q[0]);
      chk("BUS_RVALID", BUS_RVALID, rsp_q.size() != 0);
      if (rsp_q.size() != 0) begin
         chk("BUS_RDATA", BUS_RDATA, rsp_q[0][33:2]);
         chk("BUS_RRESP", BUS_RRESP, rsp_q[0][1:0]);
      end
      chk("OUTS_CNT", OUTS_CNT, outs_m);
      chk("BUS_TIMEOUT", BUS_TIMEOUT, to_m);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 4'h0, 32'($urandom), 1'b1);
         cycle();
      end
   endtask

   task automatic model_reset();
      ar_q.delete();
      sl_q.delete();
      rsp_q.delete();
      outs_m = 0;
      wc_m   = 0;
      to_m   = 1'b0;
   endtask

   initial begin
      cyc = 0;
      model_reset();
      drive(1'b0, 4'h0, 32'h0, 1'b0);
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      RDATA   = '0;
      RRESP   = '0;

      // Reset state
      #12;
      chk_reset_vals();
      chk("ARPROT", ARPROT, 3'b010);
      ARESET = 1'b0;
      @(posedge ACLK);
      #1;

      // Single read, latency and data
      fix_data_en = 1'b1;
      fix_data    = 32'hDEAD_BEEF;
      drive(1'b1, 4'h0, 32'h1000, 1'b1);
      cycle();
      chk("lat_arvalid_c1", ARVALID, 1);
      chk("lat_araddr_c1", ARADDR, 32'h1000);
      drive(1'b0, 4'h0, 32'h0, 1'b1);
      cycle();
      chk("lat_rvalid_c2", BUS_RVALID, 0);
      cycle();
      chk("lat_rvalid_c3", BUS_RVALID, 1);
      chk("lat_rdata_c3", BUS_RDATA, 32'hDEAD_BEEF);
      cycle();
      chk("single_outs_zero", OUTS_CNT, 0);
      fix_data_en = 1'b0;
      idle(3);

      // Back-to-back issue, 5-cycle slave latency
      dly_min = 5;
      dly_max = 5;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'h0, 32'(i * 4), 1'b1);
         cycle();
      end
      chk("b2b_peak", OUTS_CNT, 4);
      idle(12);
      chk("b2b_drained", OUTS_CNT, 0);

      // Full: consumer stalled, fifth request must wait for a pop
      dly_min = 1;
      dly_max = 1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'h0, 32'h100 + 32'(i * 4), 1'b0);
         cycle();
      end
      chk("full_busy", BUS_BUSY, 1);
      chk("full_outs", OUTS_CNT, 4);
      for (int i = 0; i < 4; i++) cycle();
      drive(1'b1, 4'h0, 32'h110, 1'b1);
      cycle();
      chk("full_after_pop", OUTS_CNT, 3);
      drive(1'b1, 4'h0, 32'h110, 1'b0);
      cycle();
      chk("full_fifth_accepted", OUTS_CNT, 4);
      idle(12);

      // AR stall: address held, no accept
      ar_rdy_pct = 0;
      drive(1'b1, 4'h0, 32'h2000, 1'b1);
      cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'h0, 32'h3000 + 32'(i), 1'b1);
         cycle();
      end
      chk("stall_araddr", ARADDR, 32'h2000);
      chk("stall_outs", OUTS_CNT, 1);
      ar_rdy_pct = 100;
      idle(6);

      // Stray RVALID with nothing in flight is ignored
      inject_rv = 1'b1;
      idle(1);
      inject_rv = 1'b0;
      idle(1);
      chk("stray_rvalid_ignored", BUS_RVALID, 0);

      // Randomized traffic
      ar_rdy_pct = 70;
      dly_min    = 1;
      dly_max    = 5;
      resp_sel   = -1;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(99) < 70,
               ($urandom_range(99) < 20) ? 4'($urandom_range(15, 1)) : 4'h0,
               32'($urandom_range(1023)) << 2,
               $urandom_range(99) < 70);
         cycle();
      end
      ar_rdy_pct = 100;
      resp_sel   = 0;
      idle(20);

      // Timeout: slave withholds the response
      hold_r = 1'b1;
      dly_min = 1;
      dly_max = 1;
      drive(1'b1, 4'h0, 32'h500, 1'b1);
      cycle();
      drive(1'b0, 4'h0, 32'h0, 1'b1);
      for (int i = 0; i < 8; i++) cycle();
      chk("to_not_yet", BUS_TIMEOUT, 0);
      cycle();
      chk("to_set", BUS_TIMEOUT, 1);
      idle(3);
      hold_r = 1'b0;
      idle(3);
      chk("to_sticky", BUS_TIMEOUT, 1);
      chk("to_data_delivered", OUTS_CNT, 0);

      // Reset with two reads outstanding
      hold_r = 1'b1;
      drive(1'b1, 4'h0, 32'h600, 1'b1);
      cycle();
      drive(1'b1, 4'h0, 32'h604, 1'b1);
      cycle();
      idle(2);
      chk("pre_rst_outs", OUTS_CNT, 2);
      ARESET = 1'b1;
      #1;
      chk_reset_vals();
      model_reset();
      hold_r = 1'b0;
      #3;
      ARESET = 1'b0;
      @(posedge ACLK);
      #1;
      idle(2);

      // SLVERR passthrough
      resp_sel = 2;
      drive(1'b1, 4'h0, 32'h40, 1'b0);
      cycle();
      drive(1'b0, 4'h0, 32'h0, 1'b0);
      cycle();
      cycle();
      chk("slverr_valid", BUS_RVALID, 1);
      chk("slverr_resp", BUS_RRESP, 2);
      chk("slverr_data", BUS_RDATA, mem_data(32'h40));
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
